// File: rtl/sdr_req_port_if.sv
// Requester and burst-memory signal bundle for sdr_req_port.
// slave is the port block itself; master is the requester/memory side.
interface sdr_req_port_if;
    logic [24:1] req_addr;
    logic        req;
    logic        ack;
    logic [15:0] rdata;
    logic        flush;
    logic [24:1] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        busy;

    modport slave (
        input  req_addr, req, flush, mem_ready, mem_valid, mem_data,
        output ack, rdata, mem_addr, mem_rd, busy
    );

    modport master (
        output req_addr, req, flush, mem_ready, mem_valid, mem_data,
        input  ack, rdata, mem_addr, mem_rd, busy
    );
endinterface

// File: rtl/sdr_req_port.sv
// Toggle-handshake read port with a single 4-word line buffer.
// A miss fetches one aligned 4-beat burst from downstream memory.
module sdr_req_port (
    input  logic          CLK_96M,
    input  logic          RESET,
    sdr_req_port_if.slave bus
);
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = ADDR_W - 2;
    localparam int unsigned WORDS  = 4;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t            state;
    logic [TAG_W-1:0]  tag;
    logic              valid;
    logic              flush_pending;
    logic [1:0]        beat;
    logic [ADDR_W:1]   lat_addr;
    logic [DATA_W-1:0] line [WORDS];

    logic req_new_c;
    logic hit_c;

    assign req_new_c = (bus.req != bus.ack);
    // A flush on the request cycle forces the miss path.
    assign hit_c     = valid && (tag == bus.req_addr[ADDR_W:3]) && !bus.flush;

    always_ff @(posedge CLK_96M) begin
        if (RESET) begin
            state         <= IDLE;
            bus.ack       <= 1'b0;
            bus.rdata     <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.busy      <= 1'b0;
            valid         <= 1'b0;
            flush_pending <= 1'b0;
            beat          <= 2'd0;
            tag           <= '0;
            lat_addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_new_c) begin
                        lat_addr <= bus.req_addr;
                        if (hit_c) begin
                            bus.rdata <= line[bus.req_addr[2:1]];
                            bus.ack   <= bus.req;
                        end else begin
                            bus.mem_addr <= {bus.req_addr[ADDR_W:3], 2'b00};
                            bus.mem_rd   <= 1'b1;
                            bus.busy     <= 1'b1;
                            valid        <= 1'b0;
                            state        <= REQ;
                        end
                    end else if (bus.flush) begin
                        valid <= 1'b0;
                    end
                end

                REQ: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_ready) begin
                        bus.mem_rd <= 1'b0;
                        beat       <= 2'd0;
                        state      <= FILL;
                    end
                end

                FILL: begin
                    if (bus.flush) flush_pending <= 1'b1;
                    if (bus.mem_valid) begin
                        line[beat] <= bus.mem_data;
                        beat       <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            tag   <= lat_addr[ADDR_W:3];
                            valid <= 1'b1;
                            state <= RESP;
                        end
                    end
                end

                RESP: begin
                    // A flush seen during the burst still answers this request, then drops the line.
                    bus.rdata     <= line[lat_addr[2:1]];
                    bus.ack       <= bus.req;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                    flush_pending <= 1'b0;
                    if (bus.flush || flush_pending) valid <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdr_req_port.sv
// Self-checking bench for sdr_req_port: vector table of requests with a
// behavioural memory responder, plus flush and reset corner sequences.
module tb_sdr_req_port;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [15:0] sb[$];

    sdr_req_port_if bus ();

    sdr_req_port dut (
        .CLK_96M (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        bit          flush_req;
        bit          exp_miss;
        int          ready_wait;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return 16'h00A0 + a[15:0] - 16'h0100;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Issue one request and act as the burst memory until ack matches req.
    task automatic do_req(input string name, input logic [23:0] addr, input bit exp_miss,
                          input int ready_wait, input int flush_beat, input bit flush_req);
        int          cyc, rd_cyc, first_rd, beats, phase, last_beat, ack_cyc;
        bit          done, saw_rd;
        logic [23:0] burst_addr;
        logic [15:0] exp;
        cyc = 0; rd_cyc = 0; first_rd = -1; beats = 0; phase = 0;
        last_beat = -1; ack_cyc = -1; done = 0; saw_rd = 0; burst_addr = '0;
        @(negedge clk);
        bus.req_addr = addr;
        bus.req      = ~bus.req;
        bus.flush    = flush_req;
        sb.push_back(mem_word(addr));
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.flush     = 1'b0;
            bus.mem_valid = 1'b0;
            bus.mem_ready = 1'b0;
            if (bus.ack == bus.req) begin
                done    = 1;
                ack_cyc = cyc;
            end else begin
                case (phase)
                    0: if (bus.mem_rd) begin
                        if (!saw_rd) begin
                            first_rd   = cyc;
                            burst_addr = bus.mem_addr;
                            check({name, "_busy"}, 32'(bus.busy), 32'd1);
                        end
                        saw_rd = 1;
                        rd_cyc++;
                        if (rd_cyc == ready_wait) begin
                            bus.mem_ready = 1'b1;
                            phase = 1;
                        end
                    end
                    1: begin
                        if (beats == 0) check({name, "_rd_drop"}, 32'(bus.mem_rd), 32'd0);
                        bus.mem_valid = 1'b1;
                        bus.mem_data  = mem_word({addr[23:2], 2'b00} + 24'(beats));
                        if (beats == flush_beat) bus.flush = 1'b1;
                        beats++;
                        if (beats == 4) begin
                            last_beat = cyc;
                            phase = 2;
                        end
                    end
                    default: ;
                endcase
            end
        end
        bus.mem_valid = 1'b0;
        bus.flush     = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout ack=%0b req=%0b", name, bus.ack, bus.req);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        check({name, "_rdata"}, 32'(bus.rdata), 32'(exp));
        check({name, "_miss"}, 32'(saw_rd), 32'(exp_miss));
        check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
        if (exp_miss) begin
            check({name, "_mem_addr"}, 32'(burst_addr), 32'({addr[23:2], 2'b00}));
            check({name, "_rd_first"}, 32'(first_rd), 32'd1);
            check({name, "_rd_len"}, 32'(rd_cyc), 32'(ready_wait));
            check({name, "_miss_lat"}, 32'(ack_cyc - last_beat), 32'd2);
        end else begin
            check({name, "_hit_lat"}, 32'(ack_cyc), 32'd1);
        end
    endtask

    initial begin
        bit ack_moved;
        checks = 0;
        failures = 0;
        vecs[0]  = '{24'h000100, 1'b0, 1'b1, 3};
        vecs[1]  = '{24'h000101, 1'b0, 1'b0, 1};
        vecs[2]  = '{24'h000103, 1'b0, 1'b0, 1};
        vecs[3]  = '{24'h000102, 1'b0, 1'b0, 1};
        vecs[4]  = '{24'h000104, 1'b0, 1'b1, 1};
        vecs[5]  = '{24'h000105, 1'b0, 1'b0, 1};
        vecs[6]  = '{24'h000100, 1'b0, 1'b1, 2};
        vecs[7]  = '{24'h100100, 1'b0, 1'b1, 1};
        vecs[8]  = '{24'h100103, 1'b0, 1'b0, 1};
        vecs[9]  = '{24'h100103, 1'b1, 1'b1, 1};
        vecs[10] = '{24'h100101, 1'b0, 1'b0, 1};
        vecs[11] = '{24'hFFFFFC, 1'b0, 1'b1, 4};
        vecs[12] = '{24'hFFFFFF, 1'b0, 1'b0, 1};

        rst = 1'b1;
        bus.req_addr = '0; bus.req = 1'b0; bus.flush = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_valid = 1'b0; bus.mem_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_miss,
                   vecs[i].ready_wait, -1, vecs[i].flush_req);

        // Flush during the fill: answered with fetched data, line dropped afterwards.
        do_req("flfill", 24'h000206, 1'b1, 2, 2, 1'b0);
        do_req("flfill_rep", 24'h000206, 1'b1, 1, -1, 1'b0);
        do_req("flfill_hit", 24'h000205, 1'b0, 1, -1, 1'b0);

        // Standalone flush in IDLE.
        @(negedge clk); bus.flush = 1'b1;
        @(negedge clk); bus.flush = 1'b0;
        do_req("flidle", 24'h000205, 1'b1, 1, -1, 1'b0);

        // Reset after two beats of a fill; late beats must be ignored.
        @(negedge clk);
        bus.req_addr = 24'h000300;
        bus.req = ~bus.req;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rd) begin
                bus.mem_ready = 1'b1;
                break;
            end
        end
        @(negedge clk); bus.mem_ready = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_data = 16'h1111;
        @(negedge clk); bus.mem_data = 16'h2222;
        @(negedge clk); bus.mem_valid = 1'b0; rst = 1'b1; bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mrst_ack", 32'(bus.ack), 32'd0);
        check("mrst_rdata", 32'(bus.rdata), 32'd0);
        check("mrst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("mrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_data = 16'h3333;
        @(negedge clk); bus.mem_data = 16'h4444;
        @(negedge clk); bus.mem_valid = 1'b0;
        ack_moved = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ack != 1'b0 || bus.mem_rd) ack_moved = 1;
        end
        check("mrst_quiet", 32'(ack_moved), 32'd0);
        do_req("mrst_req", 24'h000300, 1'b1, 2, -1, 1'b0);
        do_req("mrst_hit", 24'h000302, 1'b0, 1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
